// File: rtl/grover_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grover_pkg
//  Description : Shared constants, types and FSM state encoding for the
//                grover search sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package grover_pkg;

  localparam int N_ITEMS = 8;
  localparam int AMP_W   = 8;
  localparam int IDX_W   = 3;

  typedef logic [AMP_W-1:0]   amp_t;
  typedef logic [IDX_W-1:0]   idx_t;
  // Element 0 sits in the low AMP_W bits, matching the core's o7..o0 bus.
  typedef amp_t [N_ITEMS-1:0] amp_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/grover_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : grover_sched_if
//  Description : Request and result valid/ready handshakes between the host
//                (master) and the grover sequencing controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface grover_sched_if;
  import grover_pkg::*;

  logic req_valid;
  logic req_ready;
  idx_t req_target;

  logic res_valid;
  logic res_ready;
  idx_t res_index;
  amp_t res_amp;
  logic res_match;
  logic res_err;

  modport master (
    output req_valid, req_target, res_ready,
    input  req_ready, res_valid, res_index, res_amp, res_match, res_err
  );

  modport slave (
    input  req_valid, req_target, res_ready,
    output req_ready, res_valid, res_index, res_amp, res_match, res_err
  );

endinterface
`default_nettype wire

// File: rtl/grover_argmax_scan.sv
`default_nettype none
// ============================================================================
//  Module      : grover_argmax_scan
//  Description : Serial argmax over the captured amplitude vector, one entry
//                per cycle. Strict greater-than keeps the lowest index on
//                ties. index/amp present the final result in the cycle done
//                is high, so the caller can latch them on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module grover_argmax_scan
  import grover_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  amp_vec_t vec,
  output idx_t     index,
  output amp_t     amp,
  output logic     done
);

  logic r_active;
  idx_t r_cnt;
  idx_t r_best_idx;
  amp_t r_best_amp;

  amp_t w_cur;
  logic w_take;

  assign w_cur  = vec[r_cnt];
  assign w_take = (w_cur > r_best_amp);
  assign index  = w_take ? r_cnt : r_best_idx;
  assign amp    = w_take ? w_cur : r_best_amp;
  assign done   = r_active && (r_cnt == idx_t'(N_ITEMS - 1));

  // Step through the entries, folding each into the running maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active   <= 1'b0;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best_amp <= '0;
    end else if (start) begin
      r_active   <= 1'b1;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best_amp <= '0;
    end else if (r_active) begin
      r_cnt      <= r_cnt + idx_t'(1);
      r_best_idx <= index;
      r_best_amp <= amp;
      if (done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/grover_sched.sv
`default_nettype none
// ============================================================================
//  Module      : grover_sched
//  Description : Sequencing controller for the 8-entry grover search core.
//                Accepts a target, holds core_start until core_done,
//                captures the amplitudes, finds the argmax serially and
//                returns index/amplitude/match over a result handshake.
//                Optional watchdog on core_done: define GROVER_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module grover_sched
  import grover_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
)
(
  input  logic                     clk,
  input  logic                     rst,
  grover_sched_if.slave            bus,
  output logic                     core_start,
  output idx_t                     core_target,
  input  logic                     core_done,
  input  logic [N_ITEMS*AMP_W-1:0] core_amp,
  output logic                     busy
);

  state_t   r_state;
  state_t   w_state_nxt;

  idx_t     r_core_target;
  amp_vec_t r_amp_cap;
  idx_t     r_res_index;
  amp_t     r_res_amp;
  logic     r_res_match;
  logic     r_res_err;

  logic     w_accept;
  logic     w_scan_start;
  logic     w_res_take;
  logic     w_timeout;

  idx_t     w_scan_idx;
  amp_t     w_scan_amp;
  logic     w_scan_done;

  assign w_accept     = (r_state == IDLE) && bus.req_valid;
  // core_done is only looked at while WAIT is the current state.
  assign w_scan_start = (r_state == WAIT) && core_done;
  assign w_res_take   = (r_state == RESP) && bus.res_ready;

  // Outputs decoded from state so they follow an asynchronous reset at once.
  assign core_start    = (r_state == WAIT);
  assign core_target   = r_core_target;
  assign busy          = (r_state != IDLE);
  assign bus.req_ready = (r_state == IDLE);
  assign bus.res_valid = (r_state == RESP);
  assign bus.res_index = r_res_index;
  assign bus.res_amp   = r_res_amp;
  assign bus.res_match = r_res_match;
  assign bus.res_err   = r_res_err;

`ifdef GROVER_WDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] r_wd_cnt;

  // A done arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state == WAIT) && !core_done &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Count cycles spent in WAIT; held at zero outside it so WAIT starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Error flag is raised by expiry and lives until the result is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_err <= 1'b0;
    end else if (w_timeout) begin
      r_res_err <= 1'b1;
    end else if (w_res_take) begin
      r_res_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign r_res_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.req_valid) w_state_nxt = WAIT;
      WAIT: begin
        if (core_done) begin
          w_state_nxt = SCAN;
        end else if (w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      SCAN: if (w_scan_done) w_state_nxt = RESP;
      RESP: if (bus.res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the target on accept and the amplitude vector on core_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_target <= '0;
      r_amp_cap     <= '0;
    end else begin
      if (w_accept) begin
        r_core_target <= bus.req_target;
      end
      if (w_scan_start) begin
        r_amp_cap <= amp_vec_t'(core_amp);
      end
    end
  end

  // Result registers: loaded from the scanner's final step, or zeroed on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_index <= '0;
      r_res_amp   <= '0;
      r_res_match <= 1'b0;
    end else if (w_timeout) begin
      r_res_index <= '0;
      r_res_amp   <= '0;
      r_res_match <= 1'b0;
    end else if ((r_state == SCAN) && w_scan_done) begin
      r_res_index <= w_scan_idx;
      r_res_amp   <= w_scan_amp;
      r_res_match <= (w_scan_idx == r_core_target);
    end
  end

  grover_argmax_scan u_scan (
    .clk   (clk),
    .rst   (rst),
    .start (w_scan_start),
    .vec   (r_amp_cap),
    .index (w_scan_idx),
    .amp   (w_scan_amp),
    .done  (w_scan_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_grover_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_grover_sched
//  Description : Directed, table-driven bench for grover_sched, with
//                hand-written sequences for backpressure, reset, spurious
//                done and the optional watchdog (GROVER_WDOG_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grover_sched;
  import grover_pkg::*;

`ifdef GROVER_WDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       core_start;
  idx_t       core_target;
  logic       core_done = 1'b0;
  logic [N_ITEMS*AMP_W-1:0] core_amp = '0;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  grover_sched_if bus();

  grover_sched #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .core_start  (core_start),
    .core_target (core_target),
    .core_done   (core_done),
    .core_amp    (core_amp),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    idx_t     target;
    amp_vec_t amps;
    idx_t     e_idx;
    amp_t     e_amp;
    logic     e_match;
  } vec_t;

  vec_t tbl[6];

  function automatic amp_vec_t mk(input amp_t a0, input amp_t a1, input amp_t a2,
                                  input amp_t a3, input amp_t a4, input amp_t a5,
                                  input amp_t a6, input amp_t a7);
    amp_vec_t v;
    v = {a7, a6, a5, a4, a3, a2, a1, a0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake a request; returns in the first WAIT cycle.
  task automatic send_req(input idx_t t);
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_target = t;
    step();
    bus.req_valid  = 1'b0;
    chk("core_start_rise", 32'(core_start), 1);
    chk("core_target", 32'(core_target), 32'(t));
    chk("req_ready_wait", 32'(bus.req_ready), 0);
    chk("busy_wait", 32'(busy), 1);
  endtask

  // Core model: done 'delay' cycles after the first core_start cycle; then
  // walk the 9-cycle latency to res_valid.
  task automatic run_core(input int delay, input amp_vec_t a);
    core_amp = ~a;
    for (int i = 0; i < delay; i++) step();
    chk("core_start_held", 32'(core_start), 1);
    chk("res_valid_in_wait", 32'(bus.res_valid), 0);
    core_done = 1'b1;
    core_amp  = a;
    step();
    core_done = 1'b0;
    core_amp  = ~a;
    chk("core_start_drop", 32'(core_start), 0);
    for (int i = 0; i < 7; i++) step();
    chk("res_valid_k8", 32'(bus.res_valid), 0);
    step();
    chk("res_valid_k9", 32'(bus.res_valid), 1);
  endtask

  task automatic check_res(input idx_t ei, input amp_t ea, input logic em, input logic ee);
    chk("res_index", 32'(bus.res_index), 32'(ei));
    chk("res_amp", 32'(bus.res_amp), 32'(ea));
    chk("res_match", 32'(bus.res_match), 32'(em));
    chk("res_err", 32'(bus.res_err), 32'(ee));
  endtask

  task automatic finish_res();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("res_valid_after_hs", 32'(bus.res_valid), 0);
    chk("req_ready_after_hs", 32'(bus.req_ready), 1);
    chk("busy_after_hs", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_target = '0;
    bus.res_ready  = 1'b0;

    tbl[0] = '{3'd3, mk(10, 20, 30, 200, 5, 5, 5, 5),         3'd3, 8'd200, 1'b1};
    tbl[1] = '{3'd6, mk(40, 40, 150, 40, 40, 40, 150, 40),    3'd2, 8'd150, 1'b0};
    tbl[2] = '{3'd5, mk(0, 0, 0, 0, 0, 0, 0, 0),              3'd0, 8'd0,   1'b0};
    tbl[3] = '{3'd0, mk(128, 127, 0, 255, 254, 255, 3, 200),  3'd3, 8'd255, 1'b0};
    tbl[4] = '{3'd0, mk(99, 98, 98, 98, 98, 98, 98, 98),      3'd0, 8'd99,  1'b1};
    tbl[5] = '{3'd7, mk(254, 254, 254, 254, 254, 254, 254, 255), 3'd7, 8'd255, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_target", 32'(core_target), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    check_res(3'd0, 8'd0, 1'b0, 1'b0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    step();

    // Spurious done and res_ready while idle.
    core_done     = 1'b1;
    core_amp      = mk(255, 255, 255, 255, 255, 255, 255, 255);
    bus.res_ready = 1'b1;
    repeat (3) step();
    core_done     = 1'b0;
    bus.res_ready = 1'b0;
    chk("spur_busy", 32'(busy), 0);
    chk("spur_res_valid", 32'(bus.res_valid), 0);
    chk("spur_req_ready", 32'(bus.req_ready), 1);
    chk("spur_core_start", 32'(core_start), 0);

    // Table-driven searches.
    for (int i = 0; i < 6; i++) begin
      send_req(tbl[i].target);
      run_core(5, tbl[i].amps);
      check_res(tbl[i].e_idx, tbl[i].e_amp, tbl[i].e_match, 1'b0);
      finish_res();
    end

    // Backpressure with an ignored second request.
    send_req(3'd3);
    run_core(5, tbl[0].amps);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_res_index", 32'(bus.res_index), 3);
      chk("bp_res_amp", 32'(bus.res_amp), 200);
      chk("bp_core_target", 32'(core_target), 3);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("bp_hs_res_valid", 32'(bus.res_valid), 0);
    chk("bp_hs_req_ready", 32'(bus.req_ready), 1);
    chk("bp_hs_core_start", 32'(core_start), 0);
    step();
    bus.req_valid = 1'b0;
    chk("bp_accept_start", 32'(core_start), 1);
    chk("bp_accept_target", 32'(core_target), 1);
    run_core(3, mk(5, 60, 7, 8, 9, 10, 11, 12));
    check_res(3'd1, 8'd60, 1'b1, 1'b0);
    finish_res();

    // Async reset while WAIT: core_start must drop without a clock edge.
    send_req(3'd5);
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_core_start", 32'(core_start), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_core_target", 32'(core_target), 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Async reset at scan step 4.
    send_req(3'd2);
    repeat (5) step();
    core_done = 1'b1;
    core_amp  = mk(1, 2, 250, 4, 5, 6, 7, 8);
    step();
    core_done = 1'b0;
    repeat (4) step();
    #2;
    rst = 1'b0;
    #1;
    chk("rsts_core_start", 32'(core_start), 0);
    chk("rsts_res_valid", 32'(bus.res_valid), 0);
    chk("rsts_busy", 32'(busy), 0);
    chk("rsts_req_ready", 32'(bus.req_ready), 1);
    check_res(3'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rsts_idle_res_valid", 32'(bus.res_valid), 0);
    send_req(3'd0);
    run_core(5, mk(77, 10, 10, 10, 10, 10, 10, 10));
    check_res(3'd0, 8'd77, 1'b1, 1'b0);
    finish_res();

`ifdef GROVER_WDOG_EN
    // Watchdog expiry after TO cycles in WAIT.
    send_req(3'd4);
    repeat (TO - 1) step();
    chk("wd_start_before", 32'(core_start), 1);
    chk("wd_valid_before", 32'(bus.res_valid), 0);
    step();
    chk("wd_res_valid", 32'(bus.res_valid), 1);
    chk("wd_core_start", 32'(core_start), 0);
    check_res(3'd0, 8'd0, 1'b0, 1'b1);
    finish_res();
    chk("wd_err_cleared", 32'(bus.res_err), 0);

    // Done on the expiry cycle: done wins.
    send_req(3'd4);
    run_core(TO - 1, mk(1, 2, 3, 4, 90, 5, 6, 7));
    check_res(3'd4, 8'd90, 1'b1, 1'b0);
    finish_res();
`else
    // Without the watchdog, WAIT holds indefinitely.
    begin
      logic all_busy;
      logic any_valid;
      logic any_err;
      all_busy  = 1'b1;
      any_valid = 1'b0;
      any_err   = 1'b0;
      send_req(3'd4);
      for (int i = 0; i < 200; i++) begin
        step();
        all_busy  = all_busy & busy & core_start;
        any_valid = any_valid | bus.res_valid;
        any_err   = any_err | bus.res_err;
      end
      chk("nowd_busy_held", 32'(all_busy), 1);
      chk("nowd_no_result", 32'(any_valid), 0);
      chk("nowd_no_err", 32'(any_err), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("nowd_recover_idle", 32'(busy), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
